alu_ctrl_sequencer: RTL and testbench
=====================================

ALU_CTRL_SEQUENCER -- requirements
Module: alu_ctrl_sequencer

Interface
REQ-001 The block SHALL have parameter NREGS, default 16, meaning general-register count (power of two, 4..32).
REQ-002 The block SHALL have parameter IRW, default 32, meaning instruction width.
REQ-003 The block SHALL have parameter CONT_MODE, default 0, meaning that when 1, a new fetch starts after DONE without a start pulse while run=1.
REQ-004 Port w_clock, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 Port w_clear, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port start, input, 1 bit: begin one instruction; sampled only in IDLE.
REQ-007 Port run, input, 1 bit: continuous-execution enable; used only when CONT_MODE=1.
REQ-008 Port ir, input, IRW bits: IR contents, with opcode at [IRW-1:IRW-5] and Ra, Rb, Rc as consecutive RW=clog2(NREGS)-bit fields below it.
REQ-009 Port mem_ready, input, 1 bit: memory data valid for the current read.
REQ-010 Outputs, 1 bit each: s_PC, s_Zlow, s_Zhigh, s_MDR, e_MAR, e_Z, e_PC, e_MDR, e_IR, e_Y, e_HI, e_LO, e_alu, w_IncPC, w_read.
REQ-011 Outputs s_R and e_R, NREGS bits each: one-hot register bus-select and register-load vectors.
REQ-012 Output alu_opcode, 5 bits: ALU operation code.
REQ-013 Outputs busy, done and illegal, 1 bit each: sequencer status.

Function
REQ-014 States SHALL be IDLE, T0, T1, T2, T3, T4, T5, T6 and DONE; all outputs are decoded from the state register and the latched fields only (Moore), with no combinational path from any input to any output.
REQ-015 IDLE SHALL go to T0 when start=1; otherwise it stays in IDLE.
REQ-016 T0 SHALL assert s_PC, e_MAR, w_IncPC and e_Z, then go to T1.
REQ-017 T1 SHALL assert w_read and e_MDR on every cycle, and s_Zlow and e_PC on its first cycle only; it stays in T1 while mem_ready=0 (unbounded wait) and goes to T2 on mem_ready=1.
REQ-018 T2 SHALL assert s_MDR and e_IR; at the end of T2 the opcode, Ra, Rb and Rc fields are latched from ir.
REQ-019 Opcode classes SHALL be: binary = add 0, sub 1, and 2, or 3, rol 7, ror 8, shr 9, shra 10, shl 11; unary = not 4, neg 12; muldiv = mul 5, div 6; illegal = 13..31.
REQ-020 Binary ops: T3 = s_R[Rb], e_Y; T4 = s_R[Rc], e_alu, e_Z with alu_opcode=op; T5 = s_Zlow, e_R[Ra], e_LO; then DONE.
REQ-021 Unary ops: T3 is skipped; T4 = s_R[Rb], e_alu, e_Z with alu_opcode=op; T5 is as for binary ops; then DONE.
REQ-022 Muldiv ops: T3 = s_R[Ra], e_Y; T4 = s_R[Rb], e_alu, e_Z; T5 = s_Zlow, e_LO (no register write); T6 = s_Zhigh, e_HI; then DONE.
REQ-023 Illegal ops: after T2, DONE SHALL assert illegal=1 together with done=1, and no register, HI, LO or Z write occurs.
REQ-024 DONE SHALL assert done for exactly one cycle, then go to IDLE; if CONT_MODE=1 and run=1 it goes to T0 instead.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 start received while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-027 At most one bit of s_* (including s_R) SHALL be 1 in any cycle, and at most one bit of e_R SHALL be 1 in any cycle.
REQ-028 Latency from start sampled at edge k (mem_ready=1): done is high in cycle k+7 for binary ops, k+6 for unary ops, k+8 for muldiv, and k+4 for illegal ops; each mem_ready=0 cycle adds one.

Reset
REQ-029 While w_clear=0 at a clock edge, the state SHALL become IDLE, latched fields SHALL become 0, and all outputs SHALL be 0, including during T1 wait and mid-execute.
REQ-030 A start asserted in the same cycle as w_clear=0 SHALL be discarded.

Structure
REQ-031 The opcode constants, class encoding and state encoding SHALL reside in the shared package ctrl_pkg.
REQ-032 The combinational sub-module instr_decode SHALL map opcode to class (binary, unary, muldiv, illegal).

Verification
REQ-033 Binary: R7=0xF0000012, R6=0x18, ir = and R1,R7,R6, mem_ready=1 -> s_R[7]+e_Y in T3, s_R[6]+alu_opcode=2 in T4, e_R[1] in T5, done at k+7.
REQ-034 Unary with memory wait: not R6,R7 with mem_ready low for 3 cycles -> T1 held 4 cycles, e_PC high in its first cycle only, e_R[6]+e_LO in T5, done at k+9.
REQ-035 Muldiv: mul R3,R4 -> e_LO in T5, e_HI+s_Zhigh in T6, e_R all-zero throughout, done at k+8.
REQ-036 Illegal and ignored start: opcode 20 -> illegal=done=1 at k+4 with no e_R, e_Z, e_HI or e_LO; start pulsed in T3 of a legal op -> no extra fetch.
REQ-037 Reset and CONT_MODE: w_clear=0 in T4 -> all outputs 0 at the next edge, state IDLE; CONT_MODE=1 with run=1 -> T0 immediately follows DONE, three instructions back-to-back with no IDLE cycle.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared opcode, instruction-class and sequencer-state encodings for the
// ALU control sequencer.
package ctrl_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_NOT  = 5'd4;
    localparam logic [4:0] OP_MUL  = 5'd5;
    localparam logic [4:0] OP_DIV  = 5'd6;
    localparam logic [4:0] OP_ROL  = 5'd7;
    localparam logic [4:0] OP_ROR  = 5'd8;
    localparam logic [4:0] OP_SHR  = 5'd9;
    localparam logic [4:0] OP_SHRA = 5'd10;
    localparam logic [4:0] OP_SHL  = 5'd11;
    localparam logic [4:0] OP_NEG  = 5'd12;

    typedef enum logic [1:0] {
        CLS_BINARY  = 2'd0,
        CLS_UNARY   = 2'd1,
        CLS_MULDIV  = 2'd2,
        CLS_ILLEGAL = 2'd3
    } op_class_e;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_T0   = 4'd1;
    localparam logic [3:0] ST_T1   = 4'd2;
    localparam logic [3:0] ST_T2   = 4'd3;
    localparam logic [3:0] ST_T3   = 4'd4;
    localparam logic [3:0] ST_T4   = 4'd5;
    localparam logic [3:0] ST_T5   = 4'd6;
    localparam logic [3:0] ST_T6   = 4'd7;
    localparam logic [3:0] ST_DONE = 4'd8;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode classifier: every opcode outside the defined set is
// reported as illegal.
module instr_decode
    import ctrl_pkg::*;
(
    input  logic [4:0] opcode_i,
    output op_class_e  class_o
);

    always_comb begin
        class_o = CLS_ILLEGAL;
        case (opcode_i)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_ROL, OP_ROR, OP_SHR, OP_SHRA, OP_SHL: class_o = CLS_BINARY;
            OP_NOT, OP_NEG:                          class_o = CLS_UNARY;
            OP_MUL, OP_DIV:                          class_o = CLS_MULDIV;
            default:                                 class_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// Moore control sequencer for a single-bus datapath: fetch (T0-T2), then a
// class-dependent execute sequence (T3-T6), finishing with a one-cycle DONE.
module alu_ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int NREGS     = 16,
    parameter int IRW       = 32,
    parameter int CONT_MODE = 0
) (
    input  logic             w_clock,
    input  logic             w_clear,
    input  logic             start,
    input  logic             run,
    input  logic [IRW-1:0]   ir,
    input  logic             mem_ready,
    output logic             s_PC,
    output logic             s_Zlow,
    output logic             s_Zhigh,
    output logic             s_MDR,
    output logic             e_MAR,
    output logic             e_Z,
    output logic             e_PC,
    output logic             e_MDR,
    output logic             e_IR,
    output logic             e_Y,
    output logic             e_HI,
    output logic             e_LO,
    output logic             e_alu,
    output logic             w_IncPC,
    output logic             w_read,
    output logic [NREGS-1:0] s_R,
    output logic [NREGS-1:0] e_R,
    output logic [4:0]       alu_opcode,
    output logic             busy,
    output logic             done,
    output logic             illegal
);

    localparam int RW = $clog2(NREGS);

    logic [3:0]    state_q, state_d;
    logic          t1_first_q, t1_first_d;
    logic [4:0]    op_q;
    logic [RW-1:0] ra_q, rb_q, rc_q;
    op_class_e     cls_q;
    op_class_e     ir_cls;
    logic          unused_ir;

    assign unused_ir = ^ir;

    // The class of the incoming IR steers the T2 branch before it is latched.
    instr_decode u_decode (
        .opcode_i (ir[IRW-1 -: 5]),
        .class_o  (ir_cls)
    );

    function automatic logic [NREGS-1:0] reg_sel(input logic [RW-1:0] idx);
        reg_sel      = '0;
        reg_sel[idx] = 1'b1;
    endfunction

    always_comb begin
        state_d    = state_q;
        t1_first_d = 1'b0;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_T0;
            ST_T0: begin
                state_d    = ST_T1;
                t1_first_d = 1'b1;
            end
            ST_T1: if (mem_ready) state_d = ST_T2;
            ST_T2: begin
                case (ir_cls)
                    CLS_BINARY, CLS_MULDIV: state_d = ST_T3;
                    CLS_UNARY:              state_d = ST_T4;
                    default:                state_d = ST_DONE;
                endcase
            end
            ST_T3:   state_d = ST_T4;
            ST_T4:   state_d = ST_T5;
            ST_T5:   state_d = (cls_q == CLS_MULDIV) ? ST_T6 : ST_DONE;
            ST_T6:   state_d = ST_DONE;
            ST_DONE: state_d = (CONT_MODE != 0 && run) ? ST_T0 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge w_clock) begin
        if (!w_clear) begin
            state_q    <= ST_IDLE;
            t1_first_q <= 1'b0;
            op_q       <= '0;
            ra_q       <= '0;
            rb_q       <= '0;
            rc_q       <= '0;
            cls_q      <= CLS_BINARY;
        end else begin
            state_q    <= state_d;
            t1_first_q <= t1_first_d;
            if (state_q == ST_T2) begin
                op_q  <= ir[IRW-1 -: 5];
                ra_q  <= ir[IRW-6 -: RW];
                rb_q  <= ir[IRW-6-RW -: RW];
                rc_q  <= ir[IRW-6-2*RW -: RW];
                cls_q <= ir_cls;
            end
        end
    end

    always_comb begin
        s_PC       = 1'b0;
        s_Zlow     = 1'b0;
        s_Zhigh    = 1'b0;
        s_MDR      = 1'b0;
        e_MAR      = 1'b0;
        e_Z        = 1'b0;
        e_PC       = 1'b0;
        e_MDR      = 1'b0;
        e_IR       = 1'b0;
        e_Y        = 1'b0;
        e_HI       = 1'b0;
        e_LO       = 1'b0;
        e_alu      = 1'b0;
        w_IncPC    = 1'b0;
        w_read     = 1'b0;
        s_R        = '0;
        e_R        = '0;
        alu_opcode = '0;
        done       = 1'b0;
        illegal    = 1'b0;
        busy       = (state_q != ST_IDLE);
        case (state_q)
            ST_T0: begin
                s_PC    = 1'b1;
                e_MAR   = 1'b1;
                w_IncPC = 1'b1;
                e_Z     = 1'b1;
            end
            ST_T1: begin
                w_read = 1'b1;
                e_MDR  = 1'b1;
                // PC update from Z happens once, not on every wait cycle.
                if (t1_first_q) begin
                    s_Zlow = 1'b1;
                    e_PC   = 1'b1;
                end
            end
            ST_T2: begin
                s_MDR = 1'b1;
                e_IR  = 1'b1;
            end
            ST_T3: begin
                s_R = reg_sel((cls_q == CLS_MULDIV) ? ra_q : rb_q);
                e_Y = 1'b1;
            end
            ST_T4: begin
                s_R        = reg_sel((cls_q == CLS_BINARY) ? rc_q : rb_q);
                e_alu      = 1'b1;
                e_Z        = 1'b1;
                alu_opcode = op_q;
            end
            ST_T5: begin
                s_Zlow = 1'b1;
                e_LO   = 1'b1;
                if (cls_q != CLS_MULDIV) e_R = reg_sel(ra_q);
            end
            ST_T6: begin
                s_Zhigh = 1'b1;
                e_HI    = 1'b1;
            end
            ST_DONE: begin
                done    = 1'b1;
                illegal = (cls_q == CLS_ILLEGAL);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Self-checking bench for alu_ctrl_sequencer: cycle-by-cycle comparison of all
// outputs against a trace built from the instruction-class rules.
module tb_alu_ctrl_sequencer;

    localparam int NR = 16;

    typedef struct packed {
        logic s_PC, s_Zlow, s_Zhigh, s_MDR, e_MAR, e_Z, e_PC, e_MDR, e_IR;
        logic e_Y, e_HI, e_LO, e_alu, w_IncPC, w_read;
        logic [NR-1:0] s_R;
        logic [NR-1:0] e_R;
        logic [4:0] aop;
        logic busy, done, illegal;
    } out_t;

    logic w_clock = 1'b0;
    logic w_clear;
    always #5 w_clock = ~w_clock;

    logic          start0, run0, mem_ready0;
    logic [31:0]   ir0;
    logic s_PC0, s_Zlow0, s_Zhigh0, s_MDR0, e_MAR0, e_Z0, e_PC0, e_MDR0, e_IR0;
    logic e_Y0, e_HI0, e_LO0, e_alu0, w_IncPC0, w_read0, busy0, done0, illegal0;
    logic [NR-1:0] s_R0, e_R0;
    logic [4:0]    aop0;

    logic          start1, run1, mem_ready1;
    logic [31:0]   ir1;
    logic s_PC1, s_Zlow1, s_Zhigh1, s_MDR1, e_MAR1, e_Z1, e_PC1, e_MDR1, e_IR1;
    logic e_Y1, e_HI1, e_LO1, e_alu1, w_IncPC1, w_read1, busy1, done1, illegal1;
    logic [NR-1:0] s_R1, e_R1;
    logic [4:0]    aop1;

    out_t obs0, obs1;
    assign obs0 = {s_PC0, s_Zlow0, s_Zhigh0, s_MDR0, e_MAR0, e_Z0, e_PC0, e_MDR0, e_IR0,
                   e_Y0, e_HI0, e_LO0, e_alu0, w_IncPC0, w_read0, s_R0, e_R0, aop0,
                   busy0, done0, illegal0};
    assign obs1 = {s_PC1, s_Zlow1, s_Zhigh1, s_MDR1, e_MAR1, e_Z1, e_PC1, e_MDR1, e_IR1,
                   e_Y1, e_HI1, e_LO1, e_alu1, w_IncPC1, w_read1, s_R1, e_R1, aop1,
                   busy1, done1, illegal1};

    alu_ctrl_sequencer #(.NREGS(NR), .IRW(32), .CONT_MODE(0)) dut0 (
        .w_clock(w_clock), .w_clear(w_clear), .start(start0), .run(run0),
        .ir(ir0), .mem_ready(mem_ready0),
        .s_PC(s_PC0), .s_Zlow(s_Zlow0), .s_Zhigh(s_Zhigh0), .s_MDR(s_MDR0),
        .e_MAR(e_MAR0), .e_Z(e_Z0), .e_PC(e_PC0), .e_MDR(e_MDR0), .e_IR(e_IR0),
        .e_Y(e_Y0), .e_HI(e_HI0), .e_LO(e_LO0), .e_alu(e_alu0),
        .w_IncPC(w_IncPC0), .w_read(w_read0), .s_R(s_R0), .e_R(e_R0),
        .alu_opcode(aop0), .busy(busy0), .done(done0), .illegal(illegal0)
    );

    alu_ctrl_sequencer #(.NREGS(NR), .IRW(32), .CONT_MODE(1)) dut1 (
        .w_clock(w_clock), .w_clear(w_clear), .start(start1), .run(run1),
        .ir(ir1), .mem_ready(mem_ready1),
        .s_PC(s_PC1), .s_Zlow(s_Zlow1), .s_Zhigh(s_Zhigh1), .s_MDR(s_MDR1),
        .e_MAR(e_MAR1), .e_Z(e_Z1), .e_PC(e_PC1), .e_MDR(e_MDR1), .e_IR(e_IR1),
        .e_Y(e_Y1), .e_HI(e_HI1), .e_LO(e_LO1), .e_alu(e_alu1),
        .w_IncPC(w_IncPC1), .w_read(w_read1), .s_R(s_R1), .e_R(e_R1),
        .alu_opcode(aop1), .busy(busy1), .done(done1), .illegal(illegal1)
    );

    int   checks   = 0;
    int   failures = 0;
    out_t exp_q[$];

    function automatic logic [31:0] mk_ir(input int op, input int ra, input int rb, input int rc);
        logic [31:0] v;
        v        = $urandom;
        v[31:27] = op[4:0];
        v[26:23] = ra[3:0];
        v[22:19] = rb[3:0];
        v[18:15] = rc[3:0];
        return v;
    endfunction

    // Reference trace: one entry per cycle, starting with the cycle after start is taken.
    function automatic void gen(input int op, input int ra, input int rb, input int rc,
                                input int waits, input bit with_idle);
        out_t e;
        bit is_bin, is_un, is_md;
        is_bin = op inside {0, 1, 2, 3, 7, 8, 9, 10, 11};
        is_un  = op inside {4, 12};
        is_md  = op inside {5, 6};
        e = '0; e.busy = 1; e.s_PC = 1; e.e_MAR = 1; e.w_IncPC = 1; e.e_Z = 1;
        exp_q.push_back(e);
        for (int w = 0; w <= waits; w++) begin
            e = '0; e.busy = 1; e.w_read = 1; e.e_MDR = 1;
            if (w == 0) begin e.s_Zlow = 1; e.e_PC = 1; end
            exp_q.push_back(e);
        end
        e = '0; e.busy = 1; e.s_MDR = 1; e.e_IR = 1;
        exp_q.push_back(e);
        if (is_bin || is_md) begin
            e = '0; e.busy = 1; e.e_Y = 1; e.s_R[is_md ? ra : rb] = 1'b1;
            exp_q.push_back(e);
        end
        if (is_bin || is_un || is_md) begin
            e = '0; e.busy = 1; e.e_alu = 1; e.e_Z = 1; e.aop = op[4:0];
            e.s_R[is_bin ? rc : rb] = 1'b1;
            exp_q.push_back(e);
            e = '0; e.busy = 1; e.s_Zlow = 1; e.e_LO = 1;
            if (!is_md) e.e_R[ra] = 1'b1;
            exp_q.push_back(e);
        end
        if (is_md) begin
            e = '0; e.busy = 1; e.s_Zhigh = 1; e.e_HI = 1;
            exp_q.push_back(e);
        end
        e = '0; e.busy = 1; e.done = 1; e.illegal = !(is_bin || is_un || is_md);
        exp_q.push_back(e);
        if (with_idle) begin
            e = '0;
            exp_q.push_back(e);
        end
    endfunction

    // stray < 0 picks a random busy cycle for an extra start pulse; 0 means none.
    task automatic run_instr(input string name, input int op, input int ra, input int rb,
                             input int rc, input int waits, input int stray, input int exp_done);
        int done_cyc;
        int stray_cyc;
        done_cyc = 0;
        exp_q.delete();
        gen(op, ra, rb, rc, waits, 1'b1);
        stray_cyc = (stray < 0) ? $urandom_range(1, exp_q.size() - 1) : stray;
        @(negedge w_clock);
        ir0 = mk_ir(op, ra, rb, rc);
        start0 = 1'b1;
        mem_ready0 = (waits == 0);
        @(posedge w_clock);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge w_clock);
            start0 = ((i + 1) == stray_cyc);
            mem_ready0 = ((i + 1) >= 2 + waits);
            checks++;
            if (obs0 !== exp_q[i]) begin
                failures++;
                $display("FAIL %s op=%0d cyc=%0d got=%h expected=%h", name, op, i + 1, obs0, exp_q[i]);
            end
            if (obs0.done && done_cyc == 0) done_cyc = i + 1;
        end
        start0 = 1'b0;
        if (exp_done > 0) begin
            checks++;
            if (done_cyc !== exp_done) begin
                failures++;
                $display("FAIL %s_latency got=%0d expected=%0d", name, done_cyc, exp_done);
            end
        end
    endtask

    task automatic test_reset();
        w_clear = 1'b0;
        start0 = 1'b1;
        ir0 = mk_ir(0, 1, 2, 3);
        mem_ready0 = 1'b1;
        repeat (2) @(posedge w_clock);
        @(negedge w_clock);
        checks++;
        if (obs0 !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h expected=0", obs0);
        end
        checks++;
        if (obs1 !== '0) begin
            failures++;
            $display("FAIL reset_outputs_cont got=%h expected=0", obs1);
        end
        w_clear = 1'b1;
        start0 = 1'b0;
        @(posedge w_clock);
        @(negedge w_clock);
        checks++;
        if (obs0 !== '0) begin
            failures++;
            $display("FAIL start_during_reset got=%h expected=0", obs0);
        end
    endtask

    task automatic test_reset_mid(input string name, input int waits, input int rst_cyc);
        @(negedge w_clock);
        ir0 = mk_ir(1, 2, 3, 4);
        start0 = 1'b1;
        mem_ready0 = (waits == 0);
        @(posedge w_clock);
        for (int c = 1; c <= rst_cyc; c++) begin
            @(negedge w_clock);
            start0 = 1'b0;
            mem_ready0 = (c >= 2 + waits);
        end
        checks++;
        if (obs0.busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_busy_before got=%b expected=1", name, obs0.busy);
        end
        w_clear = 1'b0;
        @(posedge w_clock);
        @(negedge w_clock);
        checks++;
        if (obs0 !== '0) begin
            failures++;
            $display("FAIL %s_cleared got=%h expected=0", name, obs0);
        end
        w_clear = 1'b1;
        @(posedge w_clock);
        @(negedge w_clock);
        checks++;
        if (obs0 !== '0) begin
            failures++;
            $display("FAIL %s_stays_idle got=%h expected=0", name, obs0);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            run_instr("random", $urandom_range(0, 31), $urandom_range(0, NR - 1),
                      $urandom_range(0, NR - 1), $urandom_range(0, NR - 1),
                      $urandom_range(0, 3), -1, 0);
        end
    endtask

    task automatic test_cont_mode();
        int seg1, seg2, ndone;
        bit idle_gap;
        exp_q.delete();
        gen(0, 9, 10, 11, 0, 1'b0);
        seg1 = exp_q.size();
        gen(12, 5, 2, 0, 0, 1'b0);
        seg2 = exp_q.size();
        gen(6, 1, 14, 0, 0, 1'b1);
        ndone = 0;
        idle_gap = 1'b0;
        @(negedge w_clock);
        ir1 = mk_ir(0, 9, 10, 11);
        start1 = 1'b1;
        run1 = 1'b1;
        mem_ready1 = 1'b1;
        @(posedge w_clock);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge w_clock);
            start1 = 1'b0;
            if (i == seg1) ir1 = mk_ir(12, 5, 2, 0);
            if (i == seg2) ir1 = mk_ir(6, 1, 14, 0);
            run1 = (i < exp_q.size() - 2);
            checks++;
            if (obs1 !== exp_q[i]) begin
                failures++;
                $display("FAIL cont_trace cyc=%0d got=%h expected=%h", i + 1, obs1, exp_q[i]);
            end
            if (obs1.done) ndone++;
            if (!obs1.busy && i < exp_q.size() - 1) idle_gap = 1'b1;
        end
        run1 = 1'b0;
        checks++;
        if (ndone !== 3) begin
            failures++;
            $display("FAIL cont_done_count got=%0d expected=3", ndone);
        end
        checks++;
        if (idle_gap !== 1'b0) begin
            failures++;
            $display("FAIL cont_no_idle got=%b expected=0", idle_gap);
        end
    endtask

    initial begin
        w_clear = 1'b0;
        start0 = 1'b0; run0 = 1'b0; mem_ready0 = 1'b0; ir0 = '0;
        start1 = 1'b0; run1 = 1'b0; mem_ready1 = 1'b0; ir1 = '0;
        test_reset();
        run_instr("binary_and", 2, 1, 7, 6, 0, 0, 7);
        run_instr("unary_not_wait", 4, 6, 7, 0, 3, 0, 9);
        run_instr("muldiv_mul", 5, 3, 4, 0, 0, 0, 8);
        run_instr("illegal_op20", 20, 2, 5, 9, 0, 0, 4);
        run_instr("ignored_start", 11, 15, 0, 8, 0, 4, 7);
        run_instr("ignored_start_done", 1, 0, 15, 3, 1, 8, 8);
        test_reset_mid("reset_t4", 0, 5);
        test_reset_mid("reset_t1wait", 3, 3);
        test_random();
        test_cont_mode();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
